// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin CPU/host arbiter for a shared async-read/sync-write RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rvalid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  cpu_gnt_cnt,
  output logic [CNT_W-1:0]  host_gnt_cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state;
  state_t              state_next;
  logic                sel_host;
  logic                last_host;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                any_req;
  logic                win_host;

  assign any_req   = cpu_req | host_req;
  assign ram_addr  = acc_addr;
  assign ram_wdata = acc_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // rst gates the ACCESS strobes so an aborted access never writes the RAM
  always_comb begin
    state_next = state;
    win_host   = 1'b0;
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    ram_we     = 1'b0;
    case (state)
      IDLE: begin
        win_host = host_req & (~cpu_req | ~last_host);
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = IDLE;
        cpu_gnt    = ~sel_host & ~rst;
        host_gnt   = sel_host & ~rst;
        ram_we     = acc_we & ~rst;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_host     <= 1'b0;
      last_host    <= 1'b1;
      acc_we       <= 1'b0;
      acc_addr     <= '0;
      acc_wdata    <= '0;
      rdata        <= '0;
      rvalid       <= 2'b00;
      cpu_gnt_cnt  <= '0;
      host_gnt_cnt <= '0;
    end else begin
      rvalid <= 2'b00;
      if (state == IDLE && any_req) begin
        sel_host  <= win_host;
        last_host <= win_host;
        acc_we    <= win_host ? host_we    : cpu_we;
        acc_addr  <= win_host ? host_addr  : cpu_addr;
        acc_wdata <= win_host ? host_wdata : cpu_wdata;
      end
      if (state == ACCESS) begin
        if (!acc_we) begin
          rdata  <= ram_rdata;
          rvalid <= sel_host ? 2'b10 : 2'b01;
        end
        if (sel_host) begin
          if (host_gnt_cnt != CNT_MAX) host_gnt_cnt <= host_gnt_cnt + CNT_W'(1);
        end else begin
          if (cpu_gnt_cnt != CNT_MAX) cpu_gnt_cnt <= cpu_gnt_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench for dmem_arbiter with RAM and transaction model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [9:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic       cpu_gnt, host_gnt, ram_we;
  logic [9:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic [1:0] rvalid;
  logic [15:0] cpu_gnt_cnt, host_gnt_cnt;

  // narrow-counter instance shares inputs so saturation is reachable quickly
  logic       s_cpu_gnt, s_host_gnt, s_ram_we;
  logic [9:0] s_rdata, s_ram_addr, s_ram_wdata;
  logic [1:0] s_rvalid;
  logic [1:0] s_cpu_cnt, s_host_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt),
    .rdata(rdata), .rvalid(rvalid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cpu_gnt_cnt(cpu_gnt_cnt), .host_gnt_cnt(host_gnt_cnt)
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(10), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(s_cpu_gnt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(s_host_gnt),
    .rdata(s_rdata), .rvalid(s_rvalid),
    .ram_we(s_ram_we), .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
    .cpu_gnt_cnt(s_cpu_cnt), .host_gnt_cnt(s_host_cnt)
  );

  // RAM: async read, sync write
  logic [9:0] mem [1024];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  // Reference model: pending request per requester, shadow memory, fairness bit
  typedef struct {
    bit         v;
    bit         we;
    logic [9:0] addr;
    logic [9:0] data;
  } req_t;

  req_t       pc, ph;
  logic [9:0] shadow [1024];
  bit         m_last_host;
  int         m_cpu_cnt, m_host_cnt;
  logic [9:0] m_rdata;
  bit         force_disturb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.v    = 1'b1;
    r.we   = 1'($urandom_range(0, 1));
    r.addr = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
    r.data = 10'($urandom);
    return r;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cpu_cnt"},  32'(cpu_gnt_cnt),  32'(m_cpu_cnt));
    check({tag, "_host_cnt"}, 32'(host_gnt_cnt), 32'(m_host_cnt));
    check({tag, "_sat_cpu"},  32'(s_cpu_cnt),    32'(sat3(m_cpu_cnt)));
    check({tag, "_sat_host"}, 32'(s_host_cnt),   32'(sat3(m_host_cnt)));
  endtask

  task automatic drive_pending();
    cpu_req   = pc.v; cpu_we  = pc.we; cpu_addr  = pc.addr; cpu_wdata  = pc.data;
    host_req  = ph.v; host_we = ph.we; host_addr = ph.addr; host_wdata = ph.data;
  endtask

  task automatic model_reset();
    m_last_host = 1'b1;
    m_cpu_cnt   = 0;
    m_host_cnt  = 0;
    m_rdata     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b1; host_req = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_cpu_gnt",  32'(cpu_gnt),  0);
      check("rst_host_gnt", 32'(host_gnt), 0);
      check("rst_ram_we",   32'(ram_we),   0);
      check("rst_rvalid",   32'(rvalid),   0);
    end
    check("rst_rdata",    32'(rdata),    0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    model_reset();
    check_counters("rst");
    rst = 1'b0;
    pc.v = 1'b0; ph.v = 1'b0;
    drive_pending();
  endtask

  // One arbitration slot starting in IDLE: either an idle cycle or a full transaction
  task automatic run_txn();
    bit   win_host;
    req_t w;
    drive_pending();
    if (!pc.v && !ph.v) begin
      @(posedge clk); #1;
      check("idle_cpu_gnt",  32'(cpu_gnt),  0);
      check("idle_host_gnt", 32'(host_gnt), 0);
      check("idle_ram_we",   32'(ram_we),   0);
      check("idle_rvalid",   32'(rvalid),   0);
      return;
    end
    win_host = ph.v && (!pc.v || !m_last_host);
    w = win_host ? ph : pc;
    @(posedge clk); #1;
    check("acc_cpu_gnt",   32'(cpu_gnt),   32'(!win_host));
    check("acc_host_gnt",  32'(host_gnt),  32'(win_host));
    check("acc_ram_we",    32'(ram_we),    32'(w.we));
    check("acc_ram_addr",  32'(ram_addr),  32'(w.addr));
    check("acc_ram_wdata", 32'(ram_wdata), 32'(w.data));
    check("acc_rvalid",    32'(rvalid),    0);
    m_last_host = win_host;
    if (win_host) m_host_cnt++; else m_cpu_cnt++;
    // winner drops req; scribble its bus and optionally retarget the loser mid-ACCESS
    if (win_host) begin
      ph.v = 1'b0; host_req = 1'b0; host_addr = 10'($urandom); host_we = 1'b1;
    end else begin
      pc.v = 1'b0; cpu_req = 1'b0; cpu_addr = 10'($urandom); cpu_we = 1'b1;
    end
    if (force_disturb || $urandom_range(0, 1) == 1) begin
      if (win_host && pc.v) begin
        pc.addr = 10'($urandom_range(0, 15)); cpu_addr = pc.addr;
      end else if (!win_host && ph.v) begin
        ph.addr = 10'($urandom_range(0, 15)); host_addr = ph.addr;
      end
    end
    @(posedge clk); #1;
    if (w.we) shadow[w.addr] = w.data;
    else      m_rdata = shadow[w.addr];
    check("end_rdata",    32'(rdata),    32'(m_rdata));
    check("end_rvalid",   32'(rvalid),   w.we ? 0 : (win_host ? 32'd2 : 32'd1));
    check("end_cpu_gnt",  32'(cpu_gnt),  0);
    check("end_host_gnt", 32'(host_gnt), 0);
    check("end_ram_we",   32'(ram_we),   0);
    check("end_ram_addr", 32'(ram_addr), 32'(w.addr));
    check_counters("end");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 10'((i * 37) ^ 10'h155);
      shadow[i] = 10'((i * 37) ^ 10'h155);
    end
    force_disturb = 1'b0;
    pc = '{default: 0}; ph = '{default: 0};
    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_we = 0; host_addr = 0; host_wdata = 0;

    // Reset with both requesting; first grant goes to CPU
    do_reset();
    pc = '{v: 1, we: 0, addr: 10'h003, data: 10'h000};
    ph = '{v: 1, we: 1, addr: 10'h004, data: 10'h111};
    run_txn();
    check("first_winner_cpu", 32'(cpu_gnt_cnt), 1);

    // Host write then read back
    do_reset();
    ph = '{v: 1, we: 1, addr: 10'h005, data: 10'h3A5};
    run_txn();
    ph = '{v: 1, we: 0, addr: 10'h005, data: 10'h000};
    run_txn();
    check("host_rb_rdata", 32'(rdata), 32'h3A5);

    // Both held continuously for 8 transactions: strict alternation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (!pc.v) pc = rand_req();
      if (!ph.v) ph = rand_req();
      run_txn();
    end
    check("alt_cpu_cnt",  32'(cpu_gnt_cnt),  4);
    check("alt_host_cnt", 32'(host_gnt_cnt), 4);

    // CPU read while host retargets its address during ACCESS
    do_reset();
    force_disturb = 1'b1;
    pc = '{v: 1, we: 0, addr: 10'h010, data: 10'h000};
    ph = '{v: 1, we: 0, addr: 10'h020, data: 10'h000};
    run_txn();
    run_txn();
    force_disturb = 1'b0;

    // Reset during a host-write ACCESS aborts the write
    ph = '{v: 1, we: 1, addr: 10'h007, data: ~shadow[7]};
    pc.v = 1'b0;
    drive_pending();
    @(posedge clk); #1;
    check("abort_host_gnt", 32'(host_gnt), 1);
    rst = 1'b1; host_req = 1'b0;
    #1;
    check("abort_ram_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    ph.v = 1'b0;
    check("abort_rvalid", 32'(rvalid), 0);
    ph = '{v: 1, we: 0, addr: 10'h007, data: 10'h000};
    run_txn();
    check("abort_mem_kept", 32'(rdata), 32'(shadow[7]));

    // Randomized traffic including idle slots; narrow counters saturate here
    for (int i = 0; i < 300; i++) begin
      if (!pc.v && $urandom_range(0, 2) != 0) pc = rand_req();
      if (!ph.v && $urandom_range(0, 2) != 0) ph = rand_req();
      run_txn();
    end
    check("sat_host_final", 32'(s_host_cnt), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
